// File: rtl/key_debounce_module_if.sv
// ---------------------------------------------------------------------------
// key_debounce_module_if
//   Bundle between the raw button pins, the debounce front-end and the
//   selection/timer logic of the quiz responder.
//   master : the debounce front-end (reads raw pins, drives clean levels,
//            press pulses and the tie indication)
//   slave  : the selection/timer logic (consumes clean levels and pulses)
// ---------------------------------------------------------------------------
interface key_debounce_module_if;

  // Raw mechanical buttons, polarity set by the front-end's ACTIVE_LOW.
  logic [3:0] Key_Raw;
  logic       Start_Raw;
  logic       Answer_Raw;

  // Debounced levels (1 = pressed) and one-cycle press pulses.
  logic [3:0] Key_Out;
  logic [3:0] Key_Press;
  logic       Start_Out;
  logic       Start_Press;
  logic       Answer_Out;
  logic       Answer_Press;

  // Two or more player presses landed in the same cycle.
  logic       Tie_Flag;

  modport master (
    input  Key_Raw,
    input  Start_Raw,
    input  Answer_Raw,
    output Key_Out,
    output Key_Press,
    output Start_Out,
    output Start_Press,
    output Answer_Out,
    output Answer_Press,
    output Tie_Flag
  );

  modport slave (
    input  Key_Out,
    input  Key_Press,
    input  Start_Out,
    input  Start_Press,
    input  Answer_Out,
    input  Answer_Press,
    input  Tie_Flag
  );

endinterface : key_debounce_module_if

// File: rtl/key_debounce_module.sv
// ---------------------------------------------------------------------------
// key_debounce_module
//   Input front-end for the quiz responder. Six identical channels
//   (player keys 0..3, Start, Answer) are polarity-normalised, passed
//   through a 2-FF synchroniser and debounced by a per-channel counter.
//   A level change is accepted only after DB_CYCLES consecutive cycles of
//   the new value; each accepted press produces a one-cycle pulse.
//
//   Latency from a clean raw edge to *_Out is 2 + DB_CYCLES cycles.
//
//   Optional feature (macro KEY_TIE_FLAG_EN):
//     defined     -> Tie_Flag pulses for one cycle, one cycle after two or
//                    more Key_Press bits are high together.
//     not defined -> Tie_Flag is constant 0, no tie logic is built.
// ---------------------------------------------------------------------------
module key_debounce_module #(
  parameter int DB_CYCLES  = 1_000_000,  // stable cycles to accept; >= 2
  parameter bit ACTIVE_LOW = 1'b1        // 1: raw reads 0 when pressed
) (
  input  logic                  CLK,
  input  logic                  RST,
  key_debounce_module_if.master bus
);

  localparam int NUM_CH = 6;
  localparam int CH_START  = 4;
  localparam int CH_ANSWER = 5;
  localparam int CNT_W     = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DB_CYCLES - 1);

  logic [NUM_CH-1:0] raw_vec;
  logic [NUM_CH-1:0] pressed_vec;
  logic [NUM_CH-1:0] sync_q1;
  logic [NUM_CH-1:0] sync_q2;
  logic [NUM_CH-1:0] stable_vec;
  logic [NUM_CH-1:0] stable_d_q;
  logic [NUM_CH-1:0] press_vec;

  // Gather the raw pins into channel order and normalise to pressed = 1.
  assign raw_vec     = {bus.Answer_Raw, bus.Start_Raw, bus.Key_Raw};
  assign pressed_vec = ACTIVE_LOW ? ~raw_vec : raw_vec;

  // Two-stage synchroniser for all channels; resets to the released state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      // NOTE: non-blocking so sync_q2 takes the old sync_q1, giving two real
      // flop stages; blocking here would collapse the chain into one stage.
      sync_q1 <= pressed_vec;
      sync_q2 <= sync_q1;
    end
  end

  // Per-channel debounce: counter plus accepted (stable) level.
  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [CNT_W-1:0] cnt_q;
    logic             stable_q;

    // Count consecutive cycles of disagreement; accept at terminal count,
    // restart on any bounce back to the accepted level.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        cnt_q    <= '0;
        stable_q <= 1'b0;
      end else if (sync_q2[ch] == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_TERM) begin
        stable_q <= sync_q2[ch];
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign stable_vec[ch] = stable_q;
  end : g_ch

  // Delayed copy of the accepted levels for press-edge detection.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stable_d_q <= '0;
    end else begin
      stable_d_q <= stable_vec;
    end
  end

  // NOTE: the pulse is decoded combinationally from two flops so it is high
  // on the same cycle the level rises; registering it would add a cycle.
  assign press_vec = stable_vec & ~stable_d_q;

  // Drive the bundle.
  assign bus.Key_Out      = stable_vec[3:0];
  assign bus.Key_Press    = press_vec[3:0];
  assign bus.Start_Out    = stable_vec[CH_START];
  assign bus.Start_Press  = press_vec[CH_START];
  assign bus.Answer_Out   = stable_vec[CH_ANSWER];
  assign bus.Answer_Press = press_vec[CH_ANSWER];

`ifdef KEY_TIE_FLAG_EN
  logic [3:0] key_press_vec;
  logic       multi_press;
  logic       tie_q;

  // More than one bit set: clearing the lowest set bit leaves something.
  assign key_press_vec = press_vec[3:0];
  assign multi_press   = |(key_press_vec & (key_press_vec - 4'd1));

  // Register the tie indication so it follows the colliding pulses by one.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tie_q <= 1'b0;
    end else begin
      tie_q <= multi_press;
    end
  end

  assign bus.Tie_Flag = tie_q;
`else
  assign bus.Tie_Flag = 1'b0;
`endif

endmodule : key_debounce_module

// File: tb/tb_key_debounce_module.sv
// ---------------------------------------------------------------------------
// tb_key_debounce_module
//   Directed bench for key_debounce_module with DB_CYCLES=16, ACTIVE_LOW=1.
//   Expected press pulses (cycle + channel mask) and tie pulses are queued
//   when the stimulus is driven and consumed by a monitor on the falling
//   edge. Level checks are made at fixed cycle offsets from each raw edge.
// ---------------------------------------------------------------------------
module tb_key_debounce_module;

  localparam int DB  = 16;
  localparam int LAT = DB + 2;
`ifdef KEY_TIE_FLAG_EN
  localparam logic TIE_EN = 1'b1;
`else
  localparam logic TIE_EN = 1'b0;
`endif

  typedef struct {
    int         cyc;
    logic [5:0] mask;
  } press_ev_t;

  logic CLK;
  logic RST;
  int   cyc;
  int   checks;
  int   failures;

  press_ev_t press_q[$];
  int        tie_q[$];

  key_debounce_module_if bus ();

  key_debounce_module #(
    .DB_CYCLES (DB),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  logic [5:0]  press_now;
  logic [14:0] outs_all;
  assign press_now = {bus.Answer_Press, bus.Start_Press, bus.Key_Press};
  assign outs_all  = {bus.Tie_Flag, bus.Answer_Press, bus.Answer_Out,
                      bus.Start_Press, bus.Start_Out, bus.Key_Press, bus.Key_Out};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic expect_press(input int at, input logic [5:0] mask);
    press_ev_t e;
    e.cyc  = at;
    e.mask = mask;
    press_q.push_back(e);
  endtask

  // Scoreboard consumer: every pulse must match the head of its queue, and
  // an expected pulse whose cycle has passed is reported as missed.
  always @(negedge CLK) begin
    if (press_q.size() > 0 && cyc > press_q[0].cyc) begin
      check("press_missed", cyc, press_q[0].cyc);
      void'(press_q.pop_front());
    end
    if (press_now != 6'b0) begin
      if (press_q.size() == 0) begin
        check("press_unexpected", 32'(press_now), 32'd0);
      end else begin
        press_ev_t e;
        e = press_q.pop_front();
        check("press_cycle", cyc, e.cyc);
        check("press_mask", 32'(press_now), 32'(e.mask));
      end
    end
    if (tie_q.size() > 0 && cyc > tie_q[0]) begin
      check("tie_missed", cyc, tie_q[0]);
      void'(tie_q.pop_front());
    end
    if (bus.Tie_Flag === 1'b1) begin
      if (tie_q.size() == 0) check("tie_unexpected", 32'(bus.Tie_Flag), 32'd0);
      else check("tie_cycle", cyc, tie_q.pop_front());
    end
  end

  // Watchdog: the directed sequence is a few hundred cycles long.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          c;
    logic [14:0] accum;
    checks   = 0;
    failures = 0;

    // Reset with every button released (raw high).
    RST            = 1'b1;
    bus.Key_Raw    = 4'hF;
    bus.Start_Raw  = 1'b1;
    bus.Answer_Raw = 1'b1;
    tick(3);
    check("reset_outputs", 32'(outs_all), 32'd0);
    RST = 1'b0;

    // Idle: nothing pressed, all outputs stay 0 for 100 cycles.
    accum = '0;
    repeat (100) begin
      tick(1);
      accum |= outs_all;
    end
    check("idle_outputs", 32'(accum), 32'd0);

    // Clean press and release of player key 2.
    c = cyc;
    bus.Key_Raw[2] = 1'b0;
    expect_press(c + LAT, 6'b000100);
    tick(LAT - 1);
    check("key2_before_latency", 32'(bus.Key_Out), 32'd0);
    tick(1);
    check("key2_at_latency", 32'(bus.Key_Out), 32'h4);
    tick(1);
    check("key2_pulse_one_cycle", 32'(bus.Key_Press), 32'd0);
    check("key2_level_held", 32'(bus.Key_Out), 32'h4);
    c = cyc;
    bus.Key_Raw[2] = 1'b1;
    tick(LAT - 1);
    check("key2_release_before", 32'(bus.Key_Out), 32'h4);
    tick(1);
    check("key2_release_at", 32'(bus.Key_Out), 32'd0);
    tick(5);

    // Glitch one cycle shorter than DB_CYCLES is rejected.
    bus.Key_Raw[1] = 1'b0;
    tick(DB - 1);
    bus.Key_Raw[1] = 1'b1;
    accum = '0;
    repeat (25) begin
      tick(1);
      accum |= outs_all;
    end
    check("glitch_short_rejected", 32'(accum), 32'd0);

    // Pulse of exactly DB_CYCLES is accepted, then released.
    c = cyc;
    bus.Key_Raw[1] = 1'b0;
    expect_press(c + LAT, 6'b000010);
    tick(DB);
    bus.Key_Raw[1] = 1'b1;
    tick(LAT - DB);
    check("pulse_exact_accepted", 32'(bus.Key_Out), 32'h2);
    tick(DB - 1);
    check("pulse_exact_held", 32'(bus.Key_Out), 32'h2);
    tick(1);
    check("pulse_exact_released", 32'(bus.Key_Out), 32'd0);
    tick(5);

    // Start bounces every 5 cycles for 60 cycles, then settles pressed.
    accum = '0;
    repeat (12) begin
      bus.Start_Raw = ~bus.Start_Raw;
      repeat (5) begin
        tick(1);
        accum |= outs_all;
      end
    end
    check("start_bounce_quiet", 32'(accum), 32'd0);
    c = cyc;
    bus.Start_Raw = 1'b0;
    expect_press(c + LAT, 6'b010000);
    tick(LAT - 1);
    check("start_before_latency", 32'(bus.Start_Out), 32'd0);
    tick(1);
    check("start_at_latency", 32'(bus.Start_Out), 32'd1);
    tick(1);
    bus.Start_Raw = 1'b1;
    tick(LAT + 1);
    check("start_released", 32'(bus.Start_Out), 32'd0);

    // Keys 0 and 3 together: one combined pulse and a tie one cycle later.
    c = cyc;
    bus.Key_Raw = 4'b0110;
    expect_press(c + LAT, 6'b001001);
    if (TIE_EN) tie_q.push_back(c + LAT + 1);
    tick(LAT);
    check("tie_pulse_mask", 32'(bus.Key_Press), 32'h9);
    check("tie_flag_same_cycle", 32'(bus.Tie_Flag), 32'd0);
    tick(1);
    check("tie_flag_next_cycle", 32'(bus.Tie_Flag), 32'(TIE_EN));
    tick(1);
    check("tie_flag_cleared", 32'(bus.Tie_Flag), 32'd0);
    bus.Key_Raw = 4'hF;
    tick(LAT + 2);
    check("tie_keys_released", 32'(bus.Key_Out), 32'd0);

    // Key 1 with Start together: Start never counts toward a tie.
    c = cyc;
    bus.Key_Raw[1] = 1'b0;
    bus.Start_Raw  = 1'b0;
    expect_press(c + LAT, 6'b010010);
    tick(LAT + 1);
    check("start_no_tie", 32'(bus.Tie_Flag), 32'd0);
    bus.Key_Raw[1] = 1'b1;
    bus.Start_Raw  = 1'b1;
    tick(LAT + 2);

    // Answer held across a reset pulse: partial count is discarded and the
    // press is accepted 2 + DB_CYCLES cycles after release of reset.
    bus.Answer_Raw = 1'b0;
    tick(8);
    RST = 1'b1;
    tick(1);
    check("answer_in_reset", 32'(outs_all), 32'd0);
    tick(1);
    c = cyc;
    RST = 1'b0;
    expect_press(c + LAT, 6'b100000);
    tick(LAT - 1);
    check("answer_before_latency", 32'(bus.Answer_Out), 32'd0);
    tick(1);
    check("answer_at_latency", 32'(bus.Answer_Out), 32'd1);
    tick(1);
    bus.Answer_Raw = 1'b1;
    tick(LAT + 1);
    check("answer_released", 32'(bus.Answer_Out), 32'd0);

    tick(5);
    check("press_queue_drained", 32'(press_q.size()), 32'd0);
    check("tie_queue_drained", 32'(tie_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_key_debounce_module
